// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: segment code table,
// checker state encoding and counter width.
package seg_pkg;

  localparam int CNT_W = 32;

  // Index is the hex value shown; bit7 (DP) is always off.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder: maps a segment byte back to its nibble
// and flags whether the byte is one of the sixteen legal codes.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_rx_checker.sv
// Receive-side monitor for the seconds display: decodes the segment bus and
// checks step sequence, LED toggling and update period against the 1 s tick.
module seg_rx_checker
  import seg_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 125_000_000,
  parameter int unsigned TOL      = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       Segment,
  input  logic             LED,
  output logic [3:0]       VALUE,
  output logic             VALID,
  output logic             LOCKED,
  output logic [CNT_W-1:0] PERIOD,
  output logic             ERR_CODE,
  output logic             ERR_SEQ,
  output logic             ERR_PERIOD,
  output logic [7:0]       ERR_CNT
);

  localparam logic [CNT_W-1:0] PER_LO    = CNT_W'(CLK_FREQ - TOL);
  localparam logic [CNT_W-1:0] PER_HI    = CNT_W'(CLK_FREQ + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(CLK_FREQ + TOL + 1);
  localparam logic [CNT_W-1:0] PCNT_MAX  = '1;

  logic [7:0]       s_cur, s_prev;
  logic             l_cur, l_prev;
  logic             legal;
  logic [3:0]       code;
  logic [3:0]       next_val;
  logic             seg_evt, led_tgl, step_ok, period_ok;
  logic [CNT_W-1:0] pcnt, pcnt_n, interval;
  seg_state_e       state, state_n;
  logic [3:0]       value_n;
  logic [CNT_W-1:0] period_n;
  logic             err_code_n, err_seq_n, err_per_n;

  seg7_decode u_decode (
    .seg    (s_cur),
    .legal  (legal),
    .nibble (code)
  );

  assign seg_evt   = (s_cur != s_prev);
  assign led_tgl   = (l_cur != l_prev);
  assign next_val  = VALUE + 4'd1;
  assign step_ok   = (code == next_val);
  assign interval  = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + 1'b1;
  assign period_ok = (interval >= PER_LO) && (interval <= PER_HI);
  assign LOCKED    = (state == TRACK);

  // Illegal codes override everything; otherwise each state reacts to display updates.
  always_comb begin
    state_n    = state;
    value_n    = VALUE;
    period_n   = PERIOD;
    pcnt_n     = seg_evt ? '0 : ((pcnt == PCNT_MAX) ? pcnt : pcnt + 1'b1);
    err_code_n = 1'b0;
    err_seq_n  = 1'b0;
    err_per_n  = 1'b0;
    if (!legal) begin
      state_n    = IDLE;
      err_code_n = seg_evt;
    end else begin
      case (state)
        IDLE: begin
          value_n = code;
          pcnt_n  = '0;
          state_n = ACQ;
        end
        ACQ: begin
          if (seg_evt) begin
            value_n  = code;
            period_n = interval;
            state_n  = (step_ok && led_tgl) ? TRACK : ACQ;
          end
        end
        TRACK: begin
          if (seg_evt) begin
            value_n  = code;
            period_n = interval;
            if (!(step_ok && led_tgl)) begin
              err_seq_n = 1'b1;
              state_n   = ACQ;
            end
            if (!period_ok) err_per_n = 1'b1;
          end else if (led_tgl) begin
            err_seq_n = 1'b1;
            state_n   = ACQ;
          end else if (interval == TIMEOUT) begin
            err_per_n = 1'b1;
            state_n   = ACQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_cur      <= 8'd0;
      s_prev     <= 8'd0;
      l_cur      <= 1'b0;
      l_prev     <= 1'b0;
      state      <= IDLE;
      pcnt       <= '0;
      VALUE      <= 4'd0;
      VALID      <= 1'b0;
      PERIOD     <= '0;
      ERR_CODE   <= 1'b0;
      ERR_SEQ    <= 1'b0;
      ERR_PERIOD <= 1'b0;
      ERR_CNT    <= 8'd0;
    end else begin
      s_cur      <= Segment;
      s_prev     <= s_cur;
      l_cur      <= LED;
      l_prev     <= l_cur;
      state      <= state_n;
      pcnt       <= pcnt_n;
      VALUE      <= value_n;
      VALID      <= legal;
      PERIOD     <= period_n;
      ERR_CODE   <= err_code_n;
      ERR_SEQ    <= err_seq_n;
      ERR_PERIOD <= err_per_n;
      // One count per error cycle, however many flags fire together.
      if ((err_code_n || err_seq_n || err_per_n) && (ERR_CNT != 8'hFF))
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule
